// File: rtl/pcm_word_packer.sv
// Packs pairs of PCM samples into FIFO words for the encoder's write-side FIFO.
// Holds one word while the FIFO is full, counts dropped words and marks frames.
module pcm_word_packer #(
  parameter int unsigned SAMPLE_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FRAME_SAMPLES = 80,
  parameter int unsigned FCNT_WIDTH    = 7,
  parameter int unsigned OVF_WIDTH     = 8
) (
  input  logic                    clk_wr,
  input  logic                    rst_wr_n,
  input  logic                    srst_wr_n,
  input  logic                    enable,
  input  logic                    smp_valid,
  input  logic [SAMPLE_WIDTH-1:0] smp_data,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [DATA_WIDTH-1:0]   fifo_wr_data,
  output logic                    frame_done,
  output logic [FCNT_WIDTH-1:0]   sample_cnt,
  input  logic                    ovf_clr,
  output logic [OVF_WIDTH-1:0]    ovf_cnt,
  output logic                    ovf_flag
);

  typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

  state_e                  state_q, state_d;
  logic [SAMPLE_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0]   pend_q, pend_d;
  logic                    pend_vld_q, pend_vld_d;
  logic                    frame_done_q, frame_done_d;
  logic [FCNT_WIDTH-1:0]   sample_cnt_q, sample_cnt_d;
  logic [OVF_WIDTH-1:0]    ovf_cnt_q, ovf_cnt_d;
  logic                    ovf_flag_q, ovf_flag_d;

  logic accept, word_done, drain, drop, frame_last;

  // Disabling has priority over a sample arriving in the same cycle.
  assign accept     = smp_valid & enable & (state_q != StIdle);
  assign word_done  = accept & (state_q == StHigh);
  assign drain      = pend_vld_q & ~fifo_full;
  assign drop       = word_done & pend_vld_q & ~drain;
  assign frame_last = (sample_cnt_q == FCNT_WIDTH'(FRAME_SAMPLES - 1));

  assign fifo_wr_en   = drain;
  assign fifo_wr_data = pend_q;
  assign frame_done   = frame_done_q;
  assign sample_cnt   = sample_cnt_q;
  assign ovf_cnt      = ovf_cnt_q;
  assign ovf_flag     = ovf_flag_q;

  // Pack FSM next state and low-half capture.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    if (!enable) begin
      state_d = StIdle;
      lo_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StLow;
        StLow: begin
          if (smp_valid) begin
            state_d = StHigh;
            lo_d    = smp_data;
          end
        end
        StHigh: if (smp_valid) state_d = StLow;
        default: state_d = StIdle;
      endcase
    end
  end

  // Single-entry output buffer; a word completing while it drains still loads.
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (word_done && (!pend_vld_q || drain)) begin
      pend_d     = {smp_data, lo_q};
      pend_vld_d = 1'b1;
    end else if (drain) begin
      pend_vld_d = 1'b0;
    end
  end

  // In-frame sample counter and frame marker.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    frame_done_d = 1'b0;
    if (!enable) begin
      sample_cnt_d = '0;
    end else if (accept) begin
      if (frame_last) begin
        sample_cnt_d = '0;
        frame_done_d = 1'b1;
      end else begin
        sample_cnt_d = sample_cnt_q + 1'b1;
      end
    end
  end

  // Overflow statistics; a drop in the same cycle as a clear wins.
  always_comb begin
    ovf_cnt_d  = ovf_cnt_q;
    ovf_flag_d = ovf_flag_q;
    if (drop) begin
      ovf_flag_d = 1'b1;
      if (ovf_clr)         ovf_cnt_d = OVF_WIDTH'(1);
      else if (!(&ovf_cnt_q)) ovf_cnt_d = ovf_cnt_q + 1'b1;
    end else if (ovf_clr) begin
      ovf_cnt_d  = '0;
      ovf_flag_d = 1'b0;
    end
  end

  // State registers with async reset and synchronous clear.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q      <= StIdle;
      lo_q         <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
      sample_cnt_q <= '0;
      ovf_cnt_q    <= '0;
      ovf_flag_q   <= 1'b0;
    end else if (!srst_wr_n) begin
      state_q      <= StIdle;
      lo_q         <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
      sample_cnt_q <= '0;
      ovf_cnt_q    <= '0;
      ovf_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_q         <= lo_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      frame_done_q <= frame_done_d;
      sample_cnt_q <= sample_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
      ovf_flag_q   <= ovf_flag_d;
    end
  end

endmodule

// File: tb/tb_pcm_word_packer.sv
// Scoreboard bench for pcm_word_packer: expected FIFO words are queued by the
// stimulus and popped by a negedge monitor whenever a write is presented.
module tb_pcm_word_packer;

  logic        clk_wr = 1'b0;
  logic        rst_wr_n = 1'b0;
  logic        srst_wr_n = 1'b1;
  logic        enable = 1'b0;
  logic        smp_valid = 1'b0;
  logic [15:0] smp_data = '0;
  logic        fifo_full = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        frame_done;
  logic [6:0]  sample_cnt;
  logic [7:0]  ovf_cnt;
  logic        ovf_flag;

  pcm_word_packer dut (
    .clk_wr       (clk_wr),
    .rst_wr_n     (rst_wr_n),
    .srst_wr_n    (srst_wr_n),
    .enable       (enable),
    .smp_valid    (smp_valid),
    .smp_data     (smp_data),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .frame_done   (frame_done),
    .sample_cnt   (sample_cnt),
    .ovf_clr      (ovf_clr),
    .ovf_cnt      (ovf_cnt),
    .ovf_flag     (ovf_flag)
  );

  always #5 clk_wr = ~clk_wr;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_count = 0;
  int          fd_count = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare every presented FIFO write.
  always @(negedge clk_wr) begin
    if (rst_wr_n) begin
      if (fifo_wr_en) begin
        wr_count++;
        n_checks++;
        if (fifo_full) begin
          n_fail++;
          $display("FAIL wr_while_full: got fifo_wr_en=1 with fifo_full=1, expected 0");
        end
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got %h, expected no write", fifo_wr_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (fifo_wr_data !== e) begin
            n_fail++;
            $display("FAIL wr_data: got %h, expected %h", fifo_wr_data, e);
          end
        end
      end
      if (frame_done) fd_count++;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_wr);
      #1;
    end
  endtask

  task automatic smp(input logic [15:0] d);
    smp_valid = 1'b1;
    smp_data  = d;
    @(posedge clk_wr);
    #1;
    smp_valid = 1'b0;
  endtask

  // Disable for one cycle (clears the frame counter), then re-enable.
  task automatic restart();
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
    chk({tag, "_wr_data"}, fifo_wr_data, 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_sample_cnt"}, 32'(sample_cnt), 32'd0);
    chk({tag, "_ovf_cnt"}, 32'(ovf_cnt), 32'd0);
    chk({tag, "_ovf_flag"}, 32'(ovf_flag), 32'd0);
  endtask

  initial begin
    int base;
    #12;
    chk_reset_vals("por");
    rst_wr_n = 1'b1;
    tick(1);

    // Basic pair: one write of 0x22221111, one cycle after the second sample.
    enable = 1'b1;
    tick(1);
    base = wr_count;
    exp_q.push_back(32'h2222_1111);
    smp(16'h1111);
    chk("pair_no_early_wr", 32'(wr_count - base), 32'd0);
    smp(16'h2222);
    chk("pair_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("pair_data", fifo_wr_data, 32'h2222_1111);
    chk("pair_sample_cnt", 32'(sample_cnt), 32'd2);
    tick(1);
    chk("pair_wr_single", 32'(fifo_wr_en), 32'd0);
    chk("pair_wr_count", 32'(wr_count - base), 32'd1);

    // Full frame of 80 back-to-back samples.
    restart();
    base = wr_count;
    for (int k = 0; k < 40; k++)
      exp_q.push_back({16'h1000 + 16'(2 * k + 1), 16'h1000 + 16'(2 * k)});
    for (int i = 0; i < 80; i++) begin
      if (i == 79) chk("frame_not_early", 32'(frame_done), 32'd0);
      smp(16'h1000 + 16'(i));
    end
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    chk("frame_cnt_wrap", 32'(sample_cnt), 32'd0);
    base = base;
    tick(1);
    chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
    tick(1);
    chk("frame_wr_count", 32'(wr_count - base), 32'd40);
    chk("frame_done_count", 32'(fd_count), 32'd1);

    // Full FIFO: A held, B dropped, A written once on release.
    base = wr_count;
    fifo_full = 1'b1;
    exp_q.push_back(32'hBBBB_AAAA);
    smp(16'hAAAA);
    smp(16'hBBBB);
    smp(16'hCCCC);
    smp(16'hDDDD);
    tick(2);
    chk("full_no_wr", 32'(wr_count - base), 32'd0);
    chk("full_held_data", fifo_wr_data, 32'hBBBB_AAAA);
    chk("full_ovf_cnt", 32'(ovf_cnt), 32'd1);
    chk("full_ovf_flag", 32'(ovf_flag), 32'd1);
    fifo_full = 1'b0;
    #1;
    chk("release_wr_en", 32'(fifo_wr_en), 32'd1);
    tick(3);
    chk("release_wr_once", 32'(wr_count - base), 32'd1);

    // Release in the same cycle a new word completes: old written, new held.
    base = wr_count;
    fifo_full = 1'b1;
    exp_q.push_back(32'h0202_0101);
    exp_q.push_back(32'h0404_0303);
    smp(16'h0101);
    smp(16'h0202);
    smp(16'h0303);
    fifo_full = 1'b0;
    smp(16'h0404);
    chk("sim_held_data", fifo_wr_data, 32'h0404_0303);
    chk("sim_ovf_unchanged", 32'(ovf_cnt), 32'd1);
    tick(2);
    chk("sim_wr_count", 32'(wr_count - base), 32'd2);

    // Disable with a low half held; it must be discarded.
    smp(16'h7777);
    enable = 1'b0;
    tick(1);
    chk("dis_cnt_clear", 32'(sample_cnt), 32'd0);
    enable = 1'b1;
    smp(16'h9999);  // same cycle as enable rising: ignored
    chk("dis_ignore_cnt", 32'(sample_cnt), 32'd0);
    exp_q.push_back(32'h4444_3333);
    smp(16'h3333);
    chk("dis_restart_cnt", 32'(sample_cnt), 32'd1);
    smp(16'h4444);
    chk("dis_cnt2", 32'(sample_cnt), 32'd2);
    tick(2);

    // Overflow saturation and clear-vs-drop priority.
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("clr_cnt", 32'(ovf_cnt), 32'd0);
    chk("clr_flag", 32'(ovf_flag), 32'd0);
    fifo_full = 1'b1;
    exp_q.push_back(32'h0002_0001);
    smp(16'h0001);
    smp(16'h0002);
    for (int i = 0; i < 300; i++) begin
      smp(16'h5A5A);
      smp(16'hA5A5);
    end
    chk("sat_cnt", 32'(ovf_cnt), 32'd255);
    chk("sat_flag", 32'(ovf_flag), 32'd1);
    smp(16'h1234);
    ovf_clr = 1'b1;
    smp(16'h5678);
    ovf_clr = 1'b0;
    chk("clr_drop_cnt", 32'(ovf_cnt), 32'd1);
    chk("clr_drop_flag", 32'(ovf_flag), 32'd1);

    // Async reset with a word pending: word lost, all outputs cleared.
    chk("pending_before_rst", fifo_wr_data, 32'h0002_0001);
    rst_wr_n = 1'b0;
    #2;
    chk_reset_vals("arst");
    exp_q.delete();
    rst_wr_n = 1'b1;
    fifo_full = 1'b0;
    tick(2);
    chk("arst_pend_lost", 32'(fifo_wr_en), 32'd0);

    // Synchronous clear with a word pending.
    enable = 1'b1;
    fifo_full = 1'b1;
    tick(1);
    smp(16'hCAFE);
    smp(16'hBEEF);
    chk("srst_pending", fifo_wr_data, 32'hBEEF_CAFE);
    srst_wr_n = 1'b0;
    tick(1);
    srst_wr_n = 1'b1;
    enable = 1'b0;
    fifo_full = 1'b0;
    #1;
    chk_reset_vals("srst");
    tick(2);
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcm_word_packer.md
# pcm_word_packer

Write-side feeder for the G729 encoder's asynchronous sample FIFO, running in the `clk_wr` domain. It accepts 16-bit PCM speech samples from the codec front-end and packs pairs of samples into 32-bit FIFO words. It drives the FIFO write port and holds one packed word when the FIFO reports full. It also provides 10 ms frame markers (80 samples) and overflow statistics.

## Interface
Parameters:
- `SAMPLE_WIDTH`, 16, PCM sample width.
- `DATA_WIDTH`, 32, FIFO word width.
  - Must equal 2*`SAMPLE_WIDTH`.
- `FRAME_SAMPLES`, 80, samples per speech frame.
  - Must be even and no greater than 2^`FCNT_WIDTH`.
- `FCNT_WIDTH`, 7, width of the in-frame sample counter.
- `OVF_WIDTH`, 8, width of the overflow counter.

Ports:
- `clk_wr` in 1: write-domain clock.
- `rst_wr_n` in 1: asynchronous, active-low reset.
- `srst_wr_n` in 1: synchronous active-low clear. Same effect as reset.
- `enable` in 1: packer enable.
- `smp_valid` in 1: one-cycle strobe; a sample is present on `smp_data`.
- `smp_data` in `SAMPLE_WIDTH`: PCM sample (two's complement, passed untouched).
- `fifo_full` in 1: FIFO full, synchronous to `clk_wr`.
- `fifo_wr_en` out 1: FIFO write strobe.
- `fifo_wr_data` out `DATA_WIDTH`: packed word.
- `frame_done` out 1: one-cycle pulse per completed frame.
- `sample_cnt` out `FCNT_WIDTH`: samples accepted in the current frame.
- `ovf_clr` in 1: clears `ovf_cnt` and `ovf_flag`.
- `ovf_cnt` out `OVF_WIDTH`: dropped-word count, saturating.
- `ovf_flag` out 1: sticky overflow indication.

## Operation
- Pack FSM states:
  - `IDLE`: `enable`=0.
  - `LOW`: waiting for the even sample.
  - `HIGH`: low half held, waiting for the odd sample.
- Pack FSM transitions:
  - `IDLE`→`LOW` when `enable`=1.
  - `LOW`→`HIGH` on `smp_valid`. The sample is stored in `lo_reg`.
  - `HIGH`→`LOW` on `smp_valid`. This completes a word: `{smp_data, lo_reg}`, with the odd sample in bits [31:16] and the even sample in [15:0].
  - Any state→`IDLE` when `enable`=0. A held low half is discarded and `sample_cnt` is cleared to 0.
- Samples are accepted only in `LOW`/`HIGH`. `smp_valid` in `IDLE` is ignored.
- Output buffer: a single-entry `pend_reg` with `pend_vld`.
  - `fifo_wr_en` = `pend_vld` & ~`fifo_full` (combinational). `fifo_wr_en` is never high while `fifo_full`=1.
  - `fifo_wr_data` = `pend_reg` at all times.
  - On the cycle `fifo_wr_en`=1, `pend_vld` clears at the next edge unless a new word completes in the same cycle.
- Word-completion cases:
  - Buffer empty, or draining this cycle: the new word loads `pend_reg` and `pend_vld`=1.
  - Buffer full and not draining: the new word is dropped. `ovf_cnt` increments, saturating at all-ones, and `ovf_flag` sets.
  - The held word is never overwritten.
- Pending-word drain is independent of `enable`: a held word still drains after `enable` falls.
- Frame counting:
  - `sample_cnt` increments on every accepted sample, including samples of dropped words.
  - On the `FRAME_SAMPLES`th accepted sample, `sample_cnt` wraps to 0 and `frame_done` pulses on the next cycle.
- `ovf_clr` handling: clears the counter and flag. If a drop occurs in the same cycle, the drop wins: `ovf_cnt`=1 and `ovf_flag`=1.
- Reset / `srst_wr_n` (mid-frame or with a word pending) forces the following values; the pending word is lost and is not counted as overflow:

| Signal | Value |
|---|---|
| State | `IDLE` |
| `pend_vld` | 0 |
| `fifo_wr_en` | 0 |
| `fifo_wr_data` | 0 |
| `frame_done` | 0 |
| `sample_cnt` | 0 |
| `ovf_cnt` | 0 |
| `ovf_flag` | 0 |
| `lo_reg` | 0 |

## Timing
- All state is on posedge `clk_wr`, with asynchronous clear by `rst_wr_n`.
- Latency: word-completing `smp_valid` at cycle N gives `pend_vld`=1 at N+1. `fifo_wr_en` goes high at N+1 if `fifo_full`=0 at N+1.
- A full FIFO stalls the word until the first cycle with `fifo_full`=0. There is no timeout.
- Minimum sample spacing is 1 cycle. Back-to-back samples sustain one word per 2 cycles with no drops while the FIFO is not full.
- `frame_done` lasts exactly 1 cycle, at N+1 for the frame-closing sample at N.
- `enable` rising takes effect at the next edge: a `smp_valid` in the same cycle that `enable` rises is ignored.

## Test plan
- Reset, then `enable`=1 and samples 0x1111, 0x2222 on consecutive cycles with `fifo_full`=0:
  - `fifo_wr_en` is a single pulse one cycle after 0x2222.
  - `fifo_wr_data`=0x22221111.
  - `sample_cnt`=2.
- Stream 80 back-to-back samples:
  - exactly 40 `fifo_wr_en` pulses;
  - one `frame_done` pulse one cycle after sample 80;
  - `sample_cnt` back to 0.
- Hold `fifo_full`=1 while completing word A (0xBBBBAAAA), then word B:
  - no `fifo_wr_en` while full;
  - B dropped, `ovf_cnt`=1, `ovf_flag`=1;
  - on release A is written once, and `fifo_wr_data`=0xBBBBAAAA.
- `fifo_full` released in the same cycle a new word completes: the old word is written and the new word is held. `ovf_cnt` is unchanged.
- Drop `enable` after one sample (low half held), then re-enable and send 0x3333, 0x4444:
  - the first word written is 0x44443333;
  - `sample_cnt` restarts from 0.
- Drive 300 drops with `fifo_full` stuck at 1:
  - `ovf_cnt` saturates at 255.
  - `ovf_clr` with a simultaneous drop → `ovf_cnt`=1.
  - Assert `rst_wr_n` with a word pending → all outputs return to the reset values.
